// File: rtl/if1_fetch_buffer_pkg.sv
// if1_fetch_buffer_pkg
// Shared definitions for the IF1 fetch buffer: the NOP encoding that replaces
// faulting instructions, the exception-code width and the packed layout of
// one buffered fetch entry (pc, pc_next, inst, excp, ecode = 103 bits).
package if1_fetch_buffer_pkg;

    localparam logic [31:0] INST_NOP = 32'h0340_0000;
    localparam int          ECODE_W  = 6;

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        pc_next;
        logic [31:0]        inst;
        logic               excp;
        logic [ECODE_W-1:0] ecode;
    } fetch_entry_t;

    // A faulting fetch never carries its (possibly garbage) instruction word
    // into decode; a NOP rides along with the exception instead.
    function automatic fetch_entry_t make_entry(
        input logic [31:0]        pc,
        input logic [31:0]        pc_next,
        input logic [31:0]        inst,
        input logic               excp,
        input logic [ECODE_W-1:0] ecode
    );
        fetch_entry_t e;
        e.pc      = pc;
        e.pc_next = pc_next;
        e.inst    = excp ? INST_NOP : inst;
        e.excp    = excp;
        e.ecode   = ecode;
        return e;
    endfunction

endpackage

// File: rtl/if1_fetch_buffer_fetch_fifo_mem.sv
// fetch_fifo_mem
// DEPTH x 103-bit register array holding fetch entries.
// Ports:
//   clk, rst   clock and synchronous active-high reset (clears all entries)
//   we, waddr, wdata   single write port
//   raddr, rdata       asynchronous read port
module fetch_fifo_mem
    import if1_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fetch_entry_t     wdata,
    input  logic [PTR_W-1:0] raddr,
    output fetch_entry_t     rdata
);

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if1_fetch_buffer.sv
// if1_fetch_buffer
// In-order fetch queue between the IF1 stage and decode.
// Ports:
//   clk, rst, flush                 clock, sync active-high reset, pipeline flush
//   in_valid/in_allowin, in_*       upstream beat (pc, pc_next, inst, excp, ecode)
//   out_valid/out_allowin, out_*    head entry presented to decode
//   count                           occupancy (0..DEPTH)
module if1_fetch_buffer
    import if1_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_allowin,
    input  logic [31:0]        in_pc,
    input  logic [31:0]        in_pc_next,
    input  logic [31:0]        in_inst,
    input  logic               in_excp,
    input  logic [ECODE_W-1:0] in_ecode,
    output logic               out_valid,
    input  logic               out_allowin,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc_next,
    output logic [31:0]        out_inst,
    output logic               out_excp,
    output logic [ECODE_W-1:0] out_ecode,
    output logic [PTR_W:0]     count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             enq, deq;
    fetch_entry_t     head;

    // Allowin looks only at registered occupancy, so a full buffer refuses a
    // beat even if decode drains the head in the same cycle.
    assign in_allowin = (count_q != FULL_CNT);
    assign out_valid  = (count_q != '0);
    assign enq        = in_valid & in_allowin;
    assign deq        = out_valid & out_allowin;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (enq & ~flush),
        .waddr (wr_ptr_q),
        .wdata (make_entry(in_pc, in_pc_next, in_inst, in_excp, in_ecode)),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign out_pc      = head.pc;
    assign out_pc_next = head.pc_next;
    assign out_inst    = head.inst;
    assign out_excp    = head.excp;
    assign out_ecode   = head.ecode;
    assign count       = count_q;

endmodule

// File: tb/tb_if1_fetch_buffer.sv
module tb_if1_fetch_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0340_0000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_allowin, in_excp;
    logic [31:0] in_pc, in_pc_next, in_inst;
    logic [5:0]  in_ecode;
    logic        out_valid, out_allowin, out_excp;
    logic [31:0] out_pc, out_pc_next, out_inst;
    logic [5:0]  out_ecode;
    logic [2:0]  count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    if1_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_allowin  (in_allowin),
        .in_pc       (in_pc),
        .in_pc_next  (in_pc_next),
        .in_inst     (in_inst),
        .in_excp     (in_excp),
        .in_ecode    (in_ecode),
        .out_valid   (out_valid),
        .out_allowin (out_allowin),
        .out_pc      (out_pc),
        .out_pc_next (out_pc_next),
        .out_inst    (out_inst),
        .out_excp    (out_excp),
        .out_ecode   (out_ecode),
        .count       (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Drive one cycle of inputs, clock it, and return 1ns after the edge.
    task automatic step(input logic r, input logic f, input logic iv, input logic oa,
                        input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] inst,
                        input logic ex, input logic [5:0] ec);
        rst = r; flush = f; in_valid = iv; out_allowin = oa;
        in_pc = pc; in_pc_next = pcn; in_inst = inst; in_excp = ex; in_ecode = ec;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, flush, iv, oa;
        logic [31:0] pc;
        logic [2:0]  e_cnt;
        logic        e_valid, e_allow;
        logic        chk_head;
        logic [31:0] e_pc;
        logic        chk_zero;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic f, logic iv, logic oa, logic [31:0] pc,
                                logic [2:0] c, logic v, logic a, logic ch,
                                logic [31:0] epc, logic z);
        vec_t t;
        t.rst = r; t.flush = f; t.iv = iv; t.oa = oa; t.pc = pc;
        t.e_cnt = c; t.e_valid = v; t.e_allow = a; t.chk_head = ch; t.e_pc = epc;
        t.chk_zero = z;
        return t;
    endfunction

    typedef struct {
        logic [31:0] pc, pc_next, inst;
        logic        excp;
        logic [5:0]  ecode;
    } ent_t;

    ent_t mq[$];

    initial begin
        logic [31:0] p;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b0;
        in_pc = '0; in_pc_next = '0; in_inst = '0; in_excp = 1'b0; in_ecode = '0;

        // ---- directed table ----
        tbl.push_back(mk(1,0,0,0,32'h0,              0,0,1,0,32'h0,1));
        tbl.push_back(mk(0,0,1,0,32'h1c00_0000,      1,1,1,1,32'h1c00_0000,0));
        tbl.push_back(mk(0,0,1,0,32'h1c00_0004,      2,1,1,1,32'h1c00_0000,0));
        tbl.push_back(mk(0,0,1,0,32'h1c00_0008,      3,1,1,1,32'h1c00_0000,0));
        tbl.push_back(mk(0,0,1,0,32'h1c00_000c,      4,1,0,1,32'h1c00_0000,0));
        tbl.push_back(mk(0,0,1,0,32'h1c00_0010,      4,1,0,1,32'h1c00_0000,0));
        tbl.push_back(mk(0,0,0,1,32'h0,              3,1,1,1,32'h1c00_0004,0));
        tbl.push_back(mk(0,0,0,1,32'h0,              2,1,1,1,32'h1c00_0008,0));
        tbl.push_back(mk(0,0,0,1,32'h0,              1,1,1,1,32'h1c00_000c,0));
        tbl.push_back(mk(0,0,0,1,32'h0,              0,0,1,0,32'h0,0));
        tbl.push_back(mk(0,0,1,0,32'h1c00_0020,      1,1,1,1,32'h1c00_0020,0));
        p = 32'h1c00_0020;
        for (int k = 0; k < 10; k++) begin
            tbl.push_back(mk(0,0,1,1,32'h1c00_0024 + 4*k, 1,1,1,1,32'h1c00_0024 + 4*k,0));
            p = 32'h1c00_0024 + 4*k;
        end
        tbl.push_back(mk(0,0,1,0,32'h1c00_0050,      2,1,1,1,p,0));
        tbl.push_back(mk(0,1,1,1,32'h1c00_0100,      0,0,1,0,32'h0,0));
        tbl.push_back(mk(0,0,0,0,32'h0,              0,0,1,0,32'h0,0));
        tbl.push_back(mk(0,0,1,0,32'h1c00_0200,      1,1,1,1,32'h1c00_0200,0));
        tbl.push_back(mk(0,0,1,0,32'h1c00_0204,      2,1,1,1,32'h1c00_0200,0));
        tbl.push_back(mk(0,0,1,0,32'h1c00_0208,      3,1,1,1,32'h1c00_0200,0));
        tbl.push_back(mk(1,0,1,1,32'h1c00_020c,      0,0,1,0,32'h0,1));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].oa, tbl[i].pc,
                 tbl[i].pc + 4, tbl[i].pc ^ 32'ha5a5_0000, 1'b0, 6'h0);
            chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d in_allowin", i), 32'(in_allowin), 32'(tbl[i].e_allow));
            if (tbl[i].chk_head) begin
                chk($sformatf("v%0d out_pc", i), out_pc, tbl[i].e_pc);
                chk($sformatf("v%0d out_pc_next", i), out_pc_next, tbl[i].e_pc + 4);
                chk($sformatf("v%0d out_inst", i), out_inst, tbl[i].e_pc ^ 32'ha5a5_0000);
            end
            if (tbl[i].chk_zero) begin
                chk($sformatf("v%0d zero fields", i),
                    out_pc | out_pc_next | out_inst | 32'(out_excp) | 32'(out_ecode), 32'h0);
            end
        end

        // ---- exception beat carries NOP + ecode, behind a normal beat ----
        step(0,0,1,0,32'h1c00_0300,32'h1c00_0304,32'h1111_2222,1'b0,6'h3f);
        step(0,0,1,0,32'h1c00_0304,32'h1c00_0308,32'hdead_beef,1'b1,6'h08);
        chk("excp normal head inst", out_inst, 32'h1111_2222);
        chk("excp normal head flag", 32'(out_excp), 32'h0);
        step(0,0,0,1,0,0,0,1'b0,6'h0);
        chk("excp head pc", out_pc, 32'h1c00_0304);
        chk("excp head inst", out_inst, NOP);
        chk("excp head flag", 32'(out_excp), 32'h1);
        chk("excp head ecode", 32'(out_ecode), 32'h08);
        step(0,0,0,1,0,0,0,1'b0,6'h0);
        chk("excp drained", 32'(out_valid), 32'h0);

        // ---- randomized run against a queue model ----
        step(1,0,0,0,0,0,0,1'b0,6'h0);
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            logic r, f, iv, oa, ex;
            logic [31:0] pc, pcn, inst;
            logic [5:0]  ec;
            ent_t e;
            r    = ($urandom_range(0, 59) == 0);
            f    = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            oa   = ($urandom_range(0, 2) != 0);
            ex   = ($urandom_range(0, 4) == 0);
            pc   = $urandom; pcn = $urandom; inst = $urandom; ec = 6'($urandom);
            if (r || f) begin
                mq.delete();
            end else begin
                logic do_deq, do_enq;
                do_deq = (mq.size() != 0) && oa;
                do_enq = iv && (mq.size() != DEPTH);
                if (do_deq) void'(mq.pop_front());
                if (do_enq) begin
                    e.pc = pc; e.pc_next = pcn; e.inst = ex ? NOP : inst;
                    e.excp = ex; e.ecode = ec;
                    mq.push_back(e);
                end
            end
            step(r, f, iv, oa, pc, pcn, inst, ex, ec);
            chk("rnd count", 32'(count), 32'(mq.size()));
            chk("rnd out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("rnd in_allowin", 32'(in_allowin), 32'(mq.size() != DEPTH));
            if (mq.size() != 0) begin
                chk("rnd out_pc", out_pc, mq[0].pc);
                chk("rnd out_pc_next", out_pc_next, mq[0].pc_next);
                chk("rnd out_inst", out_inst, mq[0].inst);
                chk("rnd out_excp", 32'(out_excp), 32'(mq[0].excp));
                chk("rnd out_ecode", 32'(out_ecode), 32'(mq[0].ecode));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if1_fetch_buffer.md
Name: if1_fetch_buffer

Overview:
- Consumer end of the IF0→IF1 fetch handshake. Sits after the IF0/IF1 stage register and the I-cache response.
- Accepts one fetched instruction per cycle with its pc and pc_next, plus a fetch-exception flag. Queues these in a small FIFO and presents them in order to the decode (ID) stage through a valid/allowin handshake.
- Decouples I-cache stalls from decode back-pressure; its in_allowin becomes if1_allowin upstream.

Parameters:
- DEPTH, 4, number of buffered entries; must be a power of two, ≥2.
- PTR_W, $clog2(DEPTH), width of the read and write pointers.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush (branch mispredict/exception); discards all contents.
- in_valid  in  1  upstream beat valid; connects to if1_readygo / I-cache rready.
- in_allowin  out  1  buffer can accept a beat this cycle; drives if1_allowin upstream.
- in_pc  in  32  pc of the fetched instruction (from if0_if1_pc).
- in_pc_next  in  32  predicted next pc (from if0_if1_pc_next).
- in_inst  in  32  instruction word from the I-cache.
- in_excp  in  1  fetch exception for this beat (ADEF / TLB fault).
- in_ecode  in  6  exception code; meaningful only when in_excp=1.
- out_valid  out  1  head entry valid for ID.
- out_allowin  in  1  ID accepts the head entry this cycle.
- out_pc  out  32  head pc.
- out_pc_next  out  32  head predicted next pc.
- out_inst  out  32  head instruction; 32'h0340_0000 (NOP) when out_excp=1.
- out_excp  out  1  head exception flag.
- out_ecode  out  6  head exception code.
- count  out  PTR_W+1  occupancy, for debug and perf counters.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst is synchronous and active-high. On reset: wr_ptr=rd_ptr=0, count=0, all entry storage zeroed.
  - Reset values of outputs: out_valid=0, out_pc=0, out_pc_next=0, out_excp=0, out_ecode=0, in_allowin=1. out_inst reads 0 from the zeroed head entry.
  - rst asserted mid-operation discards all entries exactly like flush.
- Handshake and flow control:
  - enq = in_valid & in_allowin.
  - deq = out_valid & out_allowin.
  - in_allowin = (count != DEPTH). It is derived from registered count only and has no combinational path from out_allowin, so a full buffer refuses a beat even when ID dequeues in the same cycle.
  - out_valid = (count != 0).
  - out_* fields are driven combinationally from entry[rd_ptr].
- Latency: a beat enqueued at edge N is visible on out_* after edge N; there is no same-cycle bypass.
- Pointers and occupancy:
  - enq writes entry[wr_ptr] and increments wr_ptr; deq increments rd_ptr.
  - Both pointers wrap modulo DEPTH by natural PTR_W-bit overflow.
  - count update: +1 on enq only, -1 on deq only, unchanged on enq&deq or on neither.
- Boundary conditions:
  - Simultaneous enq & deq at count=k (0<k<DEPTH): count stays k and FIFO order is preserved.
  - count=0: deq is impossible and enq is allowed.
  - count=DEPTH: in_allowin=0 and in_valid is ignored.
- Exception handling:
  - When in_excp=1, the stored instruction is replaced by the NOP encoding and in_ecode is stored.
  - An exception entry still flows through in order; it is not a flush.
- Flush:
  - Has priority over enq and deq in the same cycle.
  - Next cycle: wr_ptr=rd_ptr=0, count=0, out_valid=0. Storage contents are don't-care.
  - An in_valid beat present in the flush cycle is dropped.
  - in_allowin is 1 the cycle after flush.

Decomposition:
- Shared define include:
  - NOP encoding (`INST_NOP 32'h0340_0000).
  - Ecode width (`ECODE_W 6) and the existing `PC_RESET.
  - Fetch-entry field widths; entry width 32+32+32+1+6=103 bits.
- Sub-module: one natural sub-module, fetch_fifo_mem, a DEPTH×103 register array with one write port and one asynchronous read port.
- Top level: pointers, count, handshake and flush logic live in if1_fetch_buffer.

Test Plan:
- Reset, then 4 beats with pc=0x1c000000,+4,+8,+c and out_allowin=0 → count reaches 4, in_allowin=0 after the 4th edge; a 5th beat pc=0x1c000010 is not accepted.
- From full, raise out_allowin=1 for 4 cycles with in_valid=0 → out_pc sequence 0x1c000000,04,08,0c; then out_valid=0, count=0.
- Continuous in_valid and out_allowin for 10 beats from count=1 → count stays 1 and pointers wrap; output order equals input order with no loss or duplication.
- Hold count=2, assert flush together with in_valid (pc=0x1c000100) and out_allowin → next cycle count=0, out_valid=0; the 0x1c000100 beat never appears.
- Enqueue in_excp=1, in_ecode=6'h08, in_inst=0xdeadbeef → out_inst=0x03400000, out_excp=1, out_ecode=0x08 at the head.
- Assert rst mid-stream with count=3 → next cycle all outputs at their reset values and in_allowin=1.
